// File: rtl/deser_if.sv
// Serial-in / parallel-out bus for the deserializer: serial bit stream plus
// abort in one direction, assembled word, word strobe and busy flag back.
interface deser_if #(
  parameter int WIDTH = 16
);
  logic             data_i;
  logic             data_val_i;
  logic             abort_i;
  logic [WIDTH-1:0] deser_data_o;
  logic             deser_data_val_o;
  logic             busy_o;

  // Source side: produces the serial stream and consumes the parallel word
  modport master (
    output data_i,
    output data_val_i,
    output abort_i,
    input  deser_data_o,
    input  deser_data_val_o,
    input  busy_o
  );

  // Deserializer side
  modport slave (
    input  data_i,
    input  data_val_i,
    input  abort_i,
    output deser_data_o,
    output deser_data_val_o,
    output busy_o
  );
endinterface

// File: rtl/deserializer.sv
// Collects WIDTH qualified serial bits into one parallel word and presents it
// with a single-cycle valid strobe; a partial word can be dropped with abort.
module deserializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk_i,
  input  logic   srst_i,
  deser_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("deserializer: WIDTH must be within 2..64");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_q;
  logic             data_val_q;
  logic             busy_q;
  logic             accept;
  logic             word_done;

  // Abort wins over a coincident valid bit, so that bit is never accepted
  assign accept    = bus.data_val_i & ~bus.abort_i;
  assign word_done = accept && (cnt_q == LAST_CNT);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_q[WIDTH-2:0], bus.data_i};
    end else begin : g_lsb_first
      assign shifted = {bus.data_i, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (bus.abort_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (accept) begin
      cnt_d   = word_done ? '0 : cnt_q + CNT_W'(1);
      shift_d = shifted;
    end
  end

  // The output word is taken from the shifted value so the last bit is included
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      data_val_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_val_q <= word_done;
      busy_q     <= (cnt_d != '0);
      if (word_done) begin
        data_q <= shifted;
      end
    end
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_val_o = data_val_q;
  assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Drives an MSB-first and an LSB-first deserializer with one shared stream and
// compares both against a bit-queue reference model every cycle.
module tb_deserializer;

  localparam int W = 16;

  logic clk_i = 1'b0;
  logic srst_i;

  deser_if #(.WIDTH(W)) bus_msb ();
  deser_if #(.WIDTH(W)) bus_lsb ();

  deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .bus   (bus_msb.slave)
  );

  deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .bus   (bus_lsb.slave)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cycleNo  = 0;

  bit          modelBits[$];
  logic [W-1:0] expMsb;
  logic [W-1:0] expLsb;
  logic        expVal;
  logic        expBusy;

  int           msbPulses;
  int           lsbPulseCycles[$];
  logic [W-1:0] lsbPulseWords[$];
  logic [W-1:0] lastMsbWord;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  // Reference: a word is simply the first W accepted bits, placed by arrival order
  task automatic modelEdge(input bit val, input bit din, input bit abrt, input bit rst);
    expVal = 1'b0;
    if (rst) begin
      modelBits.delete();
      expMsb = '0;
      expLsb = '0;
    end else if (abrt) begin
      modelBits.delete();
    end else if (val) begin
      modelBits.push_back(din);
      if (modelBits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          expMsb[W-1-i] = modelBits[i];
          expLsb[i]     = modelBits[i];
        end
        expVal = 1'b1;
        modelBits.delete();
      end
    end
    expBusy = (modelBits.size() != 0);
  endtask

  task automatic applyStimulus(input bit val, input bit din, input bit abrt, input bit rst);
    bus_msb.data_i     = din;
    bus_msb.data_val_i = val;
    bus_msb.abort_i    = abrt;
    bus_lsb.data_i     = din;
    bus_lsb.data_val_i = val;
    bus_lsb.abort_i    = abrt;
    srst_i             = rst;
    @(posedge clk_i);
    #1;
    cycleNo++;
    modelEdge(val, din, abrt, rst);
    checkOutput("msb_val",  bus_msb.deser_data_val_o, expVal);
    checkOutput("lsb_val",  bus_lsb.deser_data_val_o, expVal);
    checkOutput("msb_busy", bus_msb.busy_o, expBusy);
    checkOutput("lsb_busy", bus_lsb.busy_o, expBusy);
    checkOutput("msb_data", bus_msb.deser_data_o, expMsb);
    checkOutput("lsb_data", bus_lsb.deser_data_o, expLsb);
    if (bus_msb.deser_data_val_o === 1'b1) begin
      msbPulses++;
      lastMsbWord = bus_msb.deser_data_o;
    end
    if (bus_lsb.deser_data_val_o === 1'b1) begin
      lsbPulseCycles.push_back(cycleNo);
      lsbPulseWords.push_back(bus_lsb.deser_data_o);
    end
  endtask

  task automatic clearCounters();
    msbPulses = 0;
    lsbPulseCycles.delete();
    lsbPulseWords.delete();
  endtask

  // Sends w most-significant bit first with minGap..maxGap idle cycles between bits
  task automatic sendWord(input logic [W-1:0] w, input int minGap, input int maxGap);
    for (int i = 0; i < W; i++) begin
      if (i > 0) begin
        int gaps = $urandom_range(maxGap, minGap);
        for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, w[W-1-i], 1'b0, 1'b0);
    end
  endtask

  task automatic sendRandomBits(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    expMsb  = '0;
    expLsb  = '0;
    expVal  = 1'b0;
    expBusy = 1'b0;
    lastMsbWord = '0;
    clearCounters();

    // Reset for three cycles, then idle: nothing may pulse
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_pulses", msbPulses + lsbPulseCycles.size(), 0);

    // A001 stream twice back to back: MSB-first gives A001, LSB-first gives 8005
    clearCounters();
    sendWord(16'hA001, 0, 0);
    checkOutput("a001_pulses", msbPulses, 1);
    checkOutput("a001_word", lastMsbWord, 16'hA001);
    sendWord(16'hA001, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_lsb_pulses", lsbPulseCycles.size(), 2);
    if (lsbPulseCycles.size() == 2) begin
      checkOutput("b2b_spacing", lsbPulseCycles[1] - lsbPulseCycles[0], W);
      checkOutput("b2b_word0", lsbPulseWords[0], 16'h8005);
      checkOutput("b2b_word1", lsbPulseWords[1], 16'h8005);
    end

    // Gapped all-ones word
    clearCounters();
    sendWord(16'hFFFF, 1, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gap_pulses", msbPulses, 1);
    checkOutput("gap_word", lastMsbWord, 16'hFFFF);

    // Abort after 9 bits with a coincident valid bit, then a clean word
    clearCounters();
    sendRandomBits(9);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    sendWord(16'h1234, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_pulses", msbPulses, 1);
    checkOutput("abort_word", lastMsbWord, 16'h1234);

    // Abort landing on what would be the final bit
    clearCounters();
    sendRandomBits(W - 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_last_pulses", msbPulses, 0);
    checkOutput("abort_last_hold", bus_msb.deser_data_o, 16'h1234);

    // Reset in the middle of a word
    clearCounters();
    sendRandomBits(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendWord(16'h00FF, 0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_pulses", msbPulses, 1);
    checkOutput("midrst_word", lastMsbWord, 16'h00FF);

    // Random traffic with occasional aborts and resets
    for (int i = 0; i < 3000; i++) begin
      bit v = ($urandom_range(99) < 70);
      bit a = ($urandom_range(99) < 3);
      bit r = ($urandom_range(299) == 0);
      applyStimulus(v, 1'($urandom), a, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
